regfile_sb: RTL
===============

Name: regfile_sb

Overview:
- Next-generation integer register file for the MCU core, parametrised in data width and depth.
- Two write ports: port A for ALU writeback and port B for late load/multicycle return.
- Two read ports with optional same-cycle write-to-read bypass.
- An integrated scoreboard of per-register busy bits lets the issue stage stall on registers with an outstanding long-latency write.

Parameters:
- DATA_W, 32, register data width in bits.
- ADDR_W, 5, register address width; DEPTH = 2**ADDR_W registers.
- BYPASS, 1, 1 = read ports forward same-cycle write data; 0 = reads see registered contents only.
- ZERO_REG, 1, 1 = register 0 reads 0, ignores writes and ignores reservations.

Ports:
- clk_i  in  1  clock, all state updates on rising edge.
- rst_i  in  1  synchronous reset, active-low.
- rd_wr_i  in  1  port A write enable.
- rd_addr_i  in  ADDR_W  port A write address.
- rd_data_i  in  DATA_W  port A write data.
- ld_wr_i  in  1  port B write enable; also clears the busy bit of ld_addr_i.
- ld_addr_i  in  ADDR_W  port B write address.
- ld_data_i  in  DATA_W  port B write data.
- rsv_i  in  1  reserve request: mark rsv_addr_i busy.
- rsv_addr_i  in  ADDR_W  register to reserve.
- rs1_addr_i  in  ADDR_W  read port 1 address.
- rs2_addr_i  in  ADDR_W  read port 2 address.
- rs1_data_o  out  DATA_W  read port 1 data, combinational.
- rs2_data_o  out  DATA_W  read port 2 data, combinational.
- rs1_busy_o  out  1  busy status of rs1_addr_i, combinational.
- rs2_busy_o  out  1  busy status of rs2_addr_i, combinational.
- wr_conflict_o  out  1  registered one-cycle pulse: both write ports targeted the same register.

Behaviour:
- Reset (rst_i=0 at a rising edge):
  - all registers cleared to 0, all busy bits 0, wr_conflict_o 0;
  - reset overrides any write or reservation in the same cycle;
  - a reset arriving while registers are reserved drops those reservations.
- Writes:
  - take effect at the rising edge where the enable is 1; visible in registered state from the next cycle.
- Port collision (rd_wr_i & ld_wr_i, rd_addr_i == ld_addr_i, address not a suppressed register 0):
  - port A data wins;
  - port B still clears the busy bit;
  - wr_conflict_o = 1 in the following cycle only.
- Register 0 (ZERO_REG=1):
  - writes to it are dropped and it always reads 0;
  - rsv_i to it is ignored and its busy bit is never set;
  - collisions on address 0 do not pulse wr_conflict_o.
- Reads:
  - combinational, zero latency.
  - BYPASS=1: read address equal to an active write address returns that write data; port A takes priority over port B.
  - BYPASS=0: reads return registered contents only.
- Busy bits:
  - set by rsv_i and cleared by ld_wr_i; port A never touches busy bits.
  - rsv_i and ld_wr_i to the same address in the same cycle: the reservation wins and the busy bit stays/becomes 1 (new outstanding operation).
  - rsv_i to an already-busy register: it stays busy; no error is reported.
  - BYPASS=1: rsN_busy_o reads 0 when ld_wr_i clears that address this cycle without a same-cycle rsv_i; rsv_i does not affect rsN_busy_o until the next cycle.
  - BYPASS=0: rsN_busy_o reflects registered busy bits only.
- Address range: full 2**ADDR_W space is implemented; there are no out-of-range addresses.

Decomposition:
- Package regfile_pkg:
  - typedefs reg_addr_t (logic[ADDR_W-1:0]) and reg_data_t (logic[DATA_W-1:0]);
  - default constants DATA_W_DEF=32 and ADDR_W_DEF=5;
  - function zero_suppress(addr) returning whether an address is a suppressed register 0.
- Sub-module regfile_rd_port: one read port containing the array mux, bypass compare/forward logic, and busy lookup. Instantiated twice.
- Storage array, write-port arbitration, scoreboard and conflict flag live in regfile_sb.

Test Plan:
- Reset, then read all 32 addresses -> every rsN_data_o = 0, every rsN_busy_o = 0, wr_conflict_o = 0.
- Port A writes 0xDEADBEEF to x5; rs1_addr_i = 5 in the same cycle -> rs1_data_o = 0xDEADBEEF with BYPASS=1, 0 with BYPASS=0; the next cycle shows 0xDEADBEEF in both builds.
- Port A writes 0x11 and port B writes 0x22 to x7 in the same cycle, with x7 previously reserved -> x7 reads 0x11, x7 busy = 0, wr_conflict_o = 1 for exactly one cycle.
- rsv_i on x9, then rs2_addr_i = 9 -> rs2_busy_o = 1; three cycles later port B writes 0xCAFE to x9 -> same cycle rs2_busy_o = 0 and rs2_data_o = 0xCAFE (BYPASS=1).
- Same cycle: rsv_i on x3 and ld_wr_i on x3 with data 0x55 -> x3 = 0x55 and x3 remains busy the following cycle.
- Writes and rsv_i to x0 with data 0xFFFFFFFF -> x0 reads 0, never busy, no conflict pulse.
- x4 reserved and holding 0x99, then rst_i low for one cycle -> x4 = 0 and not busy afterwards.

Source files
------------

// File: rtl/regfile_pkg.sv
// Shared types and helpers for the regfile_sb register file.
// Default widths and register-0 suppression test.
package regfile_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int ADDR_W_DEF = 5;

  typedef logic [ADDR_W_DEF-1:0] reg_addr_t;
  typedef logic [DATA_W_DEF-1:0] reg_data_t;

  function automatic logic zero_suppress(
    input logic [31:0] addr,
    input logic        en
  );
    return en && (addr == 32'd0);
  endfunction

endpackage

// File: rtl/regfile_rd_port.sv
// One combinational read port: array mux, write bypass
// and scoreboard busy lookup.
module regfile_rd_port
  import regfile_pkg::*;
#(
  parameter int DATA_W   = DATA_W_DEF,
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter bit BYPASS   = 1'b1,
  parameter bit ZERO_REG = 1'b1,
  parameter int DEPTH    = 2**ADDR_W
) (
  input  logic [DATA_W-1:0] regs [DEPTH],
  input  logic [DEPTH-1:0]  busy,
  input  logic [ADDR_W-1:0] addr,
  input  logic              a_we,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [DATA_W-1:0] a_data,
  input  logic              b_we,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic [DATA_W-1:0] b_data,
  input  logic              b_clr,
  input  logic              rsv_we,
  input  logic [ADDR_W-1:0] rsv_addr,
  output logic [DATA_W-1:0] data,
  output logic              busy_o
);

  // Select stored word, then forward same-cycle writes if enabled
  always_comb begin
    data   = regs[addr];
    busy_o = busy[addr];
    if (BYPASS) begin
      if (a_we && (a_addr == addr)) begin
        data = a_data;
      end else if (b_we && (b_addr == addr)) begin
        data = b_data;
      end
      if (b_clr && (b_addr == addr) &&
          !(rsv_we && (rsv_addr == addr))) begin
        busy_o = 1'b0;
      end
    end
    if (zero_suppress(32'(addr), ZERO_REG)) begin
      data = '0;
    end
  end

endmodule

// File: rtl/regfile_sb.sv
// Two-write, two-read integer register file with an
// integrated busy-bit scoreboard for long-latency writes.
module regfile_sb
  import regfile_pkg::*;
#(
  parameter int DATA_W   = DATA_W_DEF,
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter bit BYPASS   = 1'b1,
  parameter bit ZERO_REG = 1'b1
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              rd_wr_i,
  input  logic [ADDR_W-1:0] rd_addr_i,
  input  logic [DATA_W-1:0] rd_data_i,
  input  logic              ld_wr_i,
  input  logic [ADDR_W-1:0] ld_addr_i,
  input  logic [DATA_W-1:0] ld_data_i,
  input  logic              rsv_i,
  input  logic [ADDR_W-1:0] rsv_addr_i,
  input  logic [ADDR_W-1:0] rs1_addr_i,
  input  logic [ADDR_W-1:0] rs2_addr_i,
  output logic [DATA_W-1:0] rs1_data_o,
  output logic [DATA_W-1:0] rs2_data_o,
  output logic              rs1_busy_o,
  output logic              rs2_busy_o,
  output logic              wr_conflict_o
);

  localparam int DEPTH = 2**ADDR_W;

  logic [DATA_W-1:0] regs [DEPTH];
  logic [DEPTH-1:0]  busy;
  logic              a_we;
  logic              b_we;
  logic              rsv_we;
  logic              clash;
  logic              conflict;

  // Qualify write and reserve requests against register 0
  always_comb begin
    a_we   = rd_wr_i &&
             !zero_suppress(32'(rd_addr_i), ZERO_REG);
    b_we   = ld_wr_i &&
             !zero_suppress(32'(ld_addr_i), ZERO_REG);
    rsv_we = rsv_i &&
             !zero_suppress(32'(rsv_addr_i), ZERO_REG);
    clash  = a_we && b_we && (rd_addr_i == ld_addr_i);
  end

  // Storage; port A is applied last so it wins a collision
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      for (int i = 0; i < DEPTH; i++) begin
        regs[i] <= '0;
      end
    end else begin
      if (b_we) regs[ld_addr_i] <= ld_data_i;
      if (a_we) regs[rd_addr_i] <= rd_data_i;
    end
  end

  // Scoreboard: load return clears, reservation sets and wins
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      busy <= '0;
    end else begin
      if (ld_wr_i) busy[ld_addr_i] <= 1'b0;
      if (rsv_we)  busy[rsv_addr_i] <= 1'b1;
    end
  end

  // One-cycle pulse when both write ports hit one register
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      conflict <= 1'b0;
    end else begin
      conflict <= clash;
    end
  end

  assign wr_conflict_o = conflict;

  regfile_rd_port #(
    .DATA_W   (DATA_W),
    .ADDR_W   (ADDR_W),
    .BYPASS   (BYPASS),
    .ZERO_REG (ZERO_REG)
  ) u_rs1 (
    .regs     (regs),
    .busy     (busy),
    .addr     (rs1_addr_i),
    .a_we     (a_we),
    .a_addr   (rd_addr_i),
    .a_data   (rd_data_i),
    .b_we     (b_we),
    .b_addr   (ld_addr_i),
    .b_data   (ld_data_i),
    .b_clr    (ld_wr_i),
    .rsv_we   (rsv_we),
    .rsv_addr (rsv_addr_i),
    .data     (rs1_data_o),
    .busy_o   (rs1_busy_o)
  );

  regfile_rd_port #(
    .DATA_W   (DATA_W),
    .ADDR_W   (ADDR_W),
    .BYPASS   (BYPASS),
    .ZERO_REG (ZERO_REG)
  ) u_rs2 (
    .regs     (regs),
    .busy     (busy),
    .addr     (rs2_addr_i),
    .a_we     (a_we),
    .a_addr   (rd_addr_i),
    .a_data   (rd_data_i),
    .b_we     (b_we),
    .b_addr   (ld_addr_i),
    .b_data   (ld_data_i),
    .b_clr    (ld_wr_i),
    .rsv_we   (rsv_we),
    .rsv_addr (rsv_addr_i),
    .data     (rs2_data_o),
    .busy_o   (rs2_busy_o)
  );

endmodule
